seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment driver; next generation of the calculator display block.

---
 rtl/seg7_scan_ctrl_pkg.sv | 44 ++++
 rtl/seg7_scan_ctrl_glyph.sv | 42 ++++
 rtl/seg7_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// command codes, content-source encoding and the 5-bit display symbol set.
package seg7_scan_ctrl_pkg;

    localparam logic [3:0] CODE_BRIGHT_1 = 4'd0;
    localparam logic [3:0] CODE_BRIGHT_2 = 4'd1;
    localparam logic [3:0] CODE_BRIGHT_3 = 4'd2;
    localparam logic [3:0] CODE_BRIGHT_4 = 4'd3;
    localparam logic [3:0] CODE_HOLA     = 4'd4;
    localparam logic [3:0] CODE_CHAU     = 4'd5;
    localparam logic [3:0] CODE_BLANK    = 4'd6;
    localparam logic [3:0] CODE_LAMP     = 4'd7;

    typedef enum logic [1:0] {
        SRC_NUM   = 2'd0,
        SRC_TEXT  = 2'd1,
        SRC_BLANK = 2'd2,
        SRC_LAMP  = 2'd3
    } src_e;

    // Symbols 0..15 are hex digits; the rest are letters and specials
    localparam int unsigned SYM_W = 5;
    localparam logic [SYM_W-1:0] SYM_H     = 5'd16;
    localparam logic [SYM_W-1:0] SYM_O     = 5'd17;
    localparam logic [SYM_W-1:0] SYM_L     = 5'd18;
    localparam logic [SYM_W-1:0] SYM_A     = 5'd19;
    localparam logic [SYM_W-1:0] SYM_C     = 5'd20;
    localparam logic [SYM_W-1:0] SYM_U     = 5'd21;
    localparam logic [SYM_W-1:0] SYM_BLANK = 5'd22;
    localparam logic [SYM_W-1:0] SYM_ALL   = 5'd23;

    // Letter for text position pos (3 = leftmost) of "HOLA" or "CHAU"
    function automatic logic [SYM_W-1:0] text_sym(input logic chau, input logic [1:0] pos);
        logic [SYM_W-1:0] s;
        case (pos)
            2'd3:    s = chau ? SYM_C : SYM_H;
            2'd2:    s = chau ? SYM_H : SYM_O;
            2'd1:    s = chau ? SYM_A : SYM_L;
            default: s = chau ? SYM_U : SYM_A;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_glyph.sv
// Combinational symbol to active-low segment pattern {g,f,e,d,c,b,a}.
module seg7_scan_ctrl_glyph
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic [6:0]       seg_n_c
);

    logic [6:0] seg_on;

    always_comb begin
        seg_on = 7'h00;
        case (sym)
            5'd0:    seg_on = 7'h3F;
            5'd1:    seg_on = 7'h06;
            5'd2:    seg_on = 7'h5B;
            5'd3:    seg_on = 7'h4F;
            5'd4:    seg_on = 7'h66;
            5'd5:    seg_on = 7'h6D;
            5'd6:    seg_on = 7'h7D;
            5'd7:    seg_on = 7'h07;
            5'd8:    seg_on = 7'h7F;
            5'd9:    seg_on = 7'h6F;
            5'd10:   seg_on = 7'h77;
            5'd11:   seg_on = 7'h7C;
            5'd12:   seg_on = 7'h39;
            5'd13:   seg_on = 7'h5E;
            5'd14:   seg_on = 7'h79;
            5'd15:   seg_on = 7'h71;
            SYM_H:   seg_on = 7'h76;
            SYM_O:   seg_on = 7'h3F;
            SYM_L:   seg_on = 7'h38;
            SYM_A:   seg_on = 7'h77;
            SYM_C:   seg_on = 7'h39;
            SYM_U:   seg_on = 7'h3E;
            SYM_ALL: seg_on = 7'h7F;
            default: seg_on = 7'h00;
        endcase
        seg_n_c = ~seg_on;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment driver with PWM brightness, leading-zero
// blanking and content updates committed only at frame boundaries.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter  int unsigned N_DIGITS = 8,
    parameter  int unsigned DIV      = 1000,
    parameter  int unsigned LZB      = 1,
    localparam int unsigned DP_W     = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [DP_W-1:0]       dp,
    input  logic [3:0]            code,
    input  logic [4*N_DIGITS-1:0] num,
    output logic [N_DIGITS-1:0]   an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int unsigned PW      = $clog2(DIV);
    localparam int unsigned TW      = PW + 1;
    localparam int unsigned QUARTER = DIV / 4;
    localparam int unsigned NW      = 4 * N_DIGITS;

    logic [PW-1:0]       presc_q, presc_d;
    logic [DP_W-1:0]     idx_q, idx_d;
    logic [1:0]          level_q, level_d;
    logic                mode_q, mode_d;
    logic [3:0]          last_code_q, last_code_d;
    logic                pend_q, pend_d;
    src_e                pend_src_q, pend_src_d;
    logic                pend_chau_q, pend_chau_d;
    logic [NW-1:0]       pend_num_q, pend_num_d;
    logic [DP_W-1:0]     pend_dp_q, pend_dp_d;
    src_e                show_src_q, show_src_d;
    logic                show_chau_q, show_chau_d;
    logic [NW-1:0]       show_num_q, show_num_d;
    logic [DP_W-1:0]     show_dp_q, show_dp_d;
    logic [N_DIGITS-1:0] an_n_q, an_n_d;
    logic [6:0]          seg_n_q, seg_n_d;
    logic                dp_n_q, dp_n_d;
    logic                frame_tick_q, frame_tick_d;

    logic                slot_end_c, frame_end_c;
    logic [TW-1:0]       thresh_c;
    logic [N_DIGITS-1:0] hi_zero_c;
    logic [3:0]          nib_c;
    logic [SYM_W-1:0]    sym_c;
    logic                dp_on_c;
    logic [6:0]          glyph_n_c;

    assign slot_end_c  = (presc_q == PW'(DIV - 1));
    assign frame_end_c = slot_end_c && (idx_q == DP_W'(N_DIGITS - 1));
    assign thresh_c    = (TW'(level_q) + TW'(1)) * TW'(QUARTER);

    // hi_zero_c[i]: every nibble at position i and above is zero
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        hi_zero_c = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            zero_run     = zero_run && (show_num_q[4*i +: 4] == 4'd0);
            hi_zero_c[i] = zero_run;
        end
    end

    // Symbol and DP for the digit currently being scanned
    always_comb begin
        sym_c   = SYM_BLANK;
        dp_on_c = 1'b0;
        nib_c   = show_num_q[{idx_q, 2'b00} +: 4];
        case (show_src_q)
            SRC_NUM: begin
                dp_on_c = (idx_q == show_dp_q);
                if ((LZB != 0) && (idx_q != '0) && (idx_q > show_dp_q) && hi_zero_c[idx_q]) begin
                    sym_c = SYM_BLANK;
                end else begin
                    sym_c = {1'b0, nib_c};
                end
            end
            SRC_TEXT: begin
                if (32'(idx_q) < 32'd4) begin
                    sym_c = text_sym(show_chau_q, idx_q[1:0]);
                end
            end
            SRC_LAMP: begin
                sym_c   = SYM_ALL;
                dp_on_c = 1'b1;
            end
            default: ;
        endcase
    end

    seg7_scan_ctrl_glyph u_glyph (
        .sym     (sym_c),
        .seg_n_c (glyph_n_c)
    );

    always_comb begin
        presc_d      = presc_q + PW'(1);
        idx_d        = idx_q;
        level_d      = level_q;
        mode_d       = mode;
        last_code_d  = last_code_q;
        pend_d       = pend_q;
        pend_src_d   = pend_src_q;
        pend_chau_d  = pend_chau_q;
        pend_num_d   = pend_num_q;
        pend_dp_d    = pend_dp_q;
        show_src_d   = show_src_q;
        show_chau_d  = show_chau_q;
        show_num_d   = show_num_q;
        show_dp_d    = show_dp_q;

        if (slot_end_c) begin
            presc_d = '0;
            idx_d   = frame_end_c ? '0 : idx_q + DP_W'(1);
        end

        // Change detection; pend_num/pend_dp double as the number shadow
        if (!mode) begin
            if (mode_q || (num != pend_num_q) || (dp != pend_dp_q)) begin
                pend_src_d = SRC_NUM;
                pend_num_d = num;
                pend_dp_d  = dp;
                pend_d     = 1'b1;
            end
        end else if (!mode_q || (code != last_code_q)) begin
            last_code_d = code;
            case (code)
                CODE_BRIGHT_1, CODE_BRIGHT_2, CODE_BRIGHT_3, CODE_BRIGHT_4: level_d = code[1:0];
                CODE_HOLA: begin
                    pend_src_d  = SRC_TEXT;
                    pend_chau_d = 1'b0;
                    pend_d      = 1'b1;
                end
                CODE_CHAU: begin
                    pend_src_d  = SRC_TEXT;
                    pend_chau_d = 1'b1;
                    pend_d      = 1'b1;
                end
                CODE_BLANK: begin
                    pend_src_d = SRC_BLANK;
                    pend_d     = 1'b1;
                end
                CODE_LAMP: begin
                    pend_src_d = SRC_LAMP;
                    pend_d     = 1'b1;
                end
                default: ;
            endcase
        end

        // Commit on the frame wrap, including a capture made in that same cycle
        if (frame_end_c && pend_d) begin
            show_src_d  = pend_src_d;
            show_chau_d = pend_chau_d;
            show_num_d  = pend_num_d;
            show_dp_d   = pend_dp_d;
            pend_d      = 1'b0;
        end

        an_n_d = '1;
        if ((sym_c != SYM_BLANK) && (TW'(presc_q) < thresh_c)) begin
            an_n_d[idx_q] = 1'b0;
        end
        seg_n_d      = glyph_n_c;
        dp_n_d       = ~dp_on_c;
        frame_tick_d = frame_end_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            level_q      <= 2'd3;
            mode_q       <= 1'b0;
            last_code_q  <= 4'd0;
            pend_q       <= 1'b0;
            pend_src_q   <= SRC_NUM;
            pend_chau_q  <= 1'b0;
            pend_num_q   <= '0;
            pend_dp_q    <= '0;
            show_src_q   <= SRC_NUM;
            show_chau_q  <= 1'b0;
            show_num_q   <= '0;
            show_dp_q    <= '0;
            an_n_q       <= '1;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            level_q      <= level_d;
            mode_q       <= mode_d;
            last_code_q  <= last_code_d;
            pend_q       <= pend_d;
            pend_src_q   <= pend_src_d;
            pend_chau_q  <= pend_chau_d;
            pend_num_q   <= pend_num_d;
            pend_dp_q    <= pend_dp_d;
            show_src_q   <= show_src_d;
            show_chau_q  <= show_chau_d;
            show_num_q   <= show_num_d;
            show_dp_q    <= show_dp_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (N_DIGITS=8, DIV=8): expected frames are
// queued as stimulus is applied and compared slot by slot as frames are scanned.
module tb_seg7_scan_ctrl;

    typedef struct packed {
        logic [7:0][6:0] seg;
        logic [7:0]      dp;
        logic [7:0][3:0] on;
    } frame_t;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [2:0]  dp;
    logic [3:0]  code;
    logic [31:0] num;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    int     n_checks;
    int     n_errors;
    frame_t exp_q[$];

    seg7_scan_ctrl #(
        .N_DIGITS (8),
        .DIV      (8),
        .LZB      (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .dp         (dp),
        .code       (code),
        .num        (num),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Active-low hex glyphs {g,f,e,d,c,b,a}
    function automatic logic [6:0] hexg(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        return g;
    endfunction

    function automatic frame_t exp_num(input logic [31:0] n, input int dpos, input int lvl);
        frame_t      f;
        logic [31:0] upper;
        for (int i = 0; i < 8; i++) begin
            upper = n >> (4 * i);
            if (i > 0 && i > dpos && upper == 32'd0) begin
                f.seg[i] = 7'h7F;
                f.dp[i]  = 1'b1;
                f.on[i]  = 4'd0;
            end else begin
                f.seg[i] = hexg(upper[3:0]);
                f.dp[i]  = (i == dpos) ? 1'b0 : 1'b1;
                f.on[i]  = 4'((lvl + 1) * 2);
            end
        end
        return f;
    endfunction

    function automatic frame_t exp_text(input logic chau, input int lvl);
        frame_t f;
        for (int i = 0; i < 8; i++) begin
            f.dp[i]  = 1'b1;
            f.on[i]  = (i < 4) ? 4'((lvl + 1) * 2) : 4'd0;
            case (i)
                0:       f.seg[i] = chau ? 7'h41 : 7'h08;
                1:       f.seg[i] = chau ? 7'h08 : 7'h47;
                2:       f.seg[i] = chau ? 7'h09 : 7'h40;
                3:       f.seg[i] = chau ? 7'h46 : 7'h09;
                default: f.seg[i] = 7'h7F;
            endcase
        end
        return f;
    endfunction

    function automatic frame_t exp_fill(input logic [6:0] s, input logic d, input logic [3:0] on);
        frame_t f;
        for (int i = 0; i < 8; i++) begin
            f.seg[i] = s;
            f.dp[i]  = d;
            f.on[i]  = on;
        end
        return f;
    endfunction

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        check({tag, "_tick"}, 32'(frame_tick), 32'd1);
    endtask

    task automatic count_to_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        check({tag, "_tick_latency"}, 32'(n), 32'd64);
    endtask

    // Scan one full frame starting right after a frame_tick cycle
    task automatic capture_frame(input string tag);
        frame_t     e;
        logic [7:0] mask;
        logic [6:0] s0;
        logic       d0;
        int         on, stray, torn, ticks;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        stray = 0;
        torn  = 0;
        ticks = 0;
        s0    = '0;
        d0    = 1'b0;
        for (int d = 0; d < 8; d++) begin
            mask = ~(8'(1) << d);
            on   = 0;
            for (int p = 0; p < 8; p++) begin
                @(negedge clk);
                if (p == 0) begin
                    s0 = seg_n;
                    d0 = dp_n;
                end else if (seg_n !== s0 || dp_n !== d0) begin
                    torn++;
                end
                if (an_n === mask) on++;
                else if (an_n !== 8'hFF) stray++;
                if (frame_tick) ticks++;
            end
            check($sformatf("%s_seg%0d", tag, d), 32'(s0), 32'(e.seg[d]));
            check($sformatf("%s_dp%0d", tag, d), 32'(d0), 32'(e.dp[d]));
            check($sformatf("%s_on%0d", tag, d), 32'(on), 32'(e.on[d]));
        end
        check({tag, "_stray_anode"}, 32'(stray), 32'd0);
        check({tag, "_torn"}, 32'(torn), 32'd0);
        check({tag, "_ticks"}, 32'(ticks), 32'd1);
        check({tag, "_tick_at_end"}, 32'(frame_tick), 32'd1);
    endtask

    task automatic run_frame(input string tag);
        wait_tick(tag);
        capture_frame(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an_n"}, 32'(an_n), 32'hFF);
        check({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
        check({tag, "_dp_n"}, 32'(dp_n), 32'd1);
        check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk  = 1'b0;
        rst  = 1'b1;
        mode = 1'b0;
        dp   = 3'd0;
        code = 4'd0;
        num  = 32'd0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        exp_q.push_back(exp_num(32'd0, 0, 3));
        rst = 1'b0;
        count_to_tick("boot");
        capture_frame("boot");

        num = 32'h0000_1234;
        exp_q.push_back(exp_num(32'h0000_1234, 0, 3));
        run_frame("num1234");

        mode = 1'b1;
        code = 4'd0;
        exp_q.push_back(exp_num(32'h0000_1234, 0, 0));
        run_frame("bright1");

        code = 4'd3;
        exp_q.push_back(exp_num(32'h0000_1234, 0, 3));
        run_frame("bright4");

        code = 4'd4;
        exp_q.push_back(exp_text(1'b0, 3));
        repeat (20) @(negedge clk);
        num = 32'h0000_5678;
        run_frame("hola");

        mode = 1'b0;
        exp_q.push_back(exp_num(32'h0000_5678, 0, 3));
        run_frame("restore");

        wait_tick("tear");
        num = 32'h0000_0011;
        repeat (10) @(negedge clk);
        num = 32'h0000_0022;
        dp  = 3'd2;
        exp_q.push_back(exp_num(32'h0000_0022, 2, 3));
        run_frame("last_wins");

        code = 4'd5;
        mode = 1'b1;
        exp_q.push_back(exp_text(1'b1, 3));
        run_frame("chau");

        code = 4'd6;
        exp_q.push_back(exp_fill(7'h7F, 1'b1, 4'd0));
        run_frame("blank");

        code = 4'd7;
        exp_q.push_back(exp_fill(7'h00, 1'b0, 4'd8));
        run_frame("lamp");

        code = 4'd12;
        exp_q.push_back(exp_fill(7'h00, 1'b0, 4'd8));
        run_frame("ignored");

        // Previous frame ended on its tick cycle (idx 0, prescaler 0); move to idx 5, prescaler 3
        repeat (43) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        exp_q.push_back(exp_num(32'd0, 0, 3));
        count_to_tick("restart");
        capture_frame("restart");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
